// File: rtl/barcodescanner_led_pkg.sv
// Shared constants and state encoding for the barcode scanner LED driver.
package barcodescanner_led_pkg;

    localparam int LED_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        FLASH = 1'b1
    } led_state_t;

endpackage

// File: rtl/barcodescanner_led_pwm.sv
// Global PWM dimmer: free-running counter compared against a fixed on-count.
module barcodescanner_led_pwm #(
    parameter int PWM_BITS = 8,
    parameter int DUTY     = 64
) (
    input  logic clk,
    input  logic reset,
    output logic pwm_on
);

    // One extra bit so that DUTY = 2^PWM_BITS compares as always-on.
    localparam logic [PWM_BITS:0] DUTY_W = (PWM_BITS + 1)'(DUTY);

    logic [PWM_BITS-1:0] pwm_cnt;

    // Free-running period counter, wraps naturally at 2^PWM_BITS-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    assign pwm_on = ({1'b0, pwm_cnt} < DUTY_W);

endmodule

// File: rtl/barcodescanner_led_driver.sv
// LED driver: PWM dimming plus a blink acknowledge on every changed LED bit.
module barcodescanner_led_driver
    import barcodescanner_led_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int DUTY        = 64,
    parameter int TICK_DIV    = 50000,
    parameter int FLASH_TICKS = 100,
    parameter int FLASH_COUNT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LED_W-1:0] pattern_in,
    input  logic             enable,
    output logic [LED_W-1:0] led_out,
    output logic             busy
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SUB_W  = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
    localparam int HALF_W = $clog2(2 * FLASH_COUNT);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(FLASH_TICKS - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * FLASH_COUNT - 1);

    led_state_t        state, state_next;
    logic [LED_W-1:0]  pat_q, mask, mask_next;
    logic [LED_W-1:0]  diff, raw;
    logic              phase, phase_next;
    logic [HALF_W-1:0] half_cnt, half_next;
    logic [SUB_W-1:0]  tick_sub, sub_next;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick, tick_clr;
    logic              pwm_on;

    barcodescanner_led_pwm #(
        .PWM_BITS (PWM_BITS),
        .DUTY     (DUTY)
    ) u_pwm (
        .clk    (clk),
        .reset  (reset),
        .pwm_on (pwm_on)
    );

    assign diff = pattern_in ^ pat_q;
    assign tick = (tick_cnt == TICK_LAST);

    // Blink-tick prescaler; restarted on entry/retrigger so half-periods are exact.
    always_ff @(posedge clk) begin
        if (reset || tick_clr || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // State and blink bookkeeping registers, plus the input pattern capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pat_q    <= '0;
            mask     <= '0;
            phase    <= 1'b0;
            half_cnt <= '0;
            tick_sub <= '0;
        end else begin
            state    <= state_next;
            pat_q    <= pattern_in;
            mask     <= mask_next;
            phase    <= phase_next;
            half_cnt <= half_next;
            tick_sub <= sub_next;
        end
    end

    // Next-state logic: a change starts or retriggers a blink, ticks advance it.
    always_comb begin
        state_next = state;
        mask_next  = mask;
        phase_next = phase;
        half_next  = half_cnt;
        sub_next   = tick_sub;
        tick_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (diff != '0) begin
                    mask_next  = diff;
                    phase_next = 1'b0;
                    half_next  = '0;
                    sub_next   = '0;
                    tick_clr   = 1'b1;
                    state_next = FLASH;
                end
            end
            FLASH: begin
                if (diff != '0) begin
                    mask_next = mask | diff;
                    half_next = '0;
                    sub_next  = '0;
                    tick_clr  = 1'b1;
                end else if (tick) begin
                    if (tick_sub == SUB_LAST) begin
                        sub_next   = '0;
                        phase_next = ~phase;
                        half_next  = half_cnt + 1'b1;
                        if (half_cnt == HALF_LAST) begin
                            state_next = IDLE;
                            mask_next  = '0;
                        end
                    end else begin
                        sub_next = tick_sub + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Masked bits follow the blink phase; everything else shows the latest pattern.
    always_comb begin
        raw = pat_q;
        if (state == FLASH) begin
            raw = (pat_q & ~mask) | (mask & {LED_W{phase}});
        end
    end

    // Registered LED drive with PWM dimming and the global enable gate.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_out <= '0;
        end else if (enable) begin
            led_out <= raw & {LED_W{pwm_on}};
        end else begin
            led_out <= '0;
        end
    end

    assign busy = (state == FLASH);

endmodule
